// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Zero-latency lookup at fetch; updates from execute on the rising edge.
module branch_target_buffer #(
    parameter  int ENTRIES  = 16,
    parameter  int CTR_BITS = 2,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int TAG_W    = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        clear,
    output logic [31:0] mispredict_cnt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [29:0]         tgt_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [31:0]         mcnt_q;
    logic [31:0]         mcnt_d;

    logic [IDX_W-1:0]    fidx;
    logic [TAG_W-1:0]    ftag;
    logic [IDX_W-1:0]    uidx;
    logic [TAG_W-1:0]    utag;
    logic                u_hit;
    logic                alloc;
    logic                bump;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_nxt;
    logic                unused;

    assign unused = ^{upd_pc[1:0], upd_target[1:0]};

    assign fidx = fetch_pc[IDX_W+1:2];
    assign ftag = fetch_pc[31:IDX_W+2];
    assign uidx = upd_pc[IDX_W+1:2];
    assign utag = upd_pc[31:IDX_W+2];

    assign hit         = valid_q[fidx] && (tag_q[fidx] == ftag);
    assign pred_taken  = hit && ctr_q[fidx][CTR_BITS-1];
    assign pred_target = pred_taken ? {tgt_q[fidx], 2'b00}
                                    : fetch_pc + 32'd4;

    // clear discards any concurrent update
    assign u_hit = valid_q[uidx] && (tag_q[uidx] == utag);
    assign alloc = upd_valid && !clear && upd_taken && !u_hit;
    assign bump  = upd_valid && !clear && u_hit;

    always_comb begin
        ctr_cur = ctr_q[uidx];
        ctr_nxt = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_BITS'(1);
        end else begin
            if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_BITS'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[uidx] <= 1'b1;
            ctr_q[uidx]   <= CTR_INIT;
        end else if (bump) begin
            ctr_q[uidx] <= ctr_nxt;
        end
    end

    // tag/target carry no reset; valid_q guards them
    always_ff @(posedge CLK) begin
        if (nRST && (alloc || (bump && upd_taken))) begin
            tag_q[uidx] <= utag;
            tgt_q[uidx] <= upd_target[31:2];
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (upd_valid && upd_mispredict && (mcnt_q != 32'hFFFF_FFFF))
            mcnt_d = mcnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) mcnt_q <= '0;
        else       mcnt_q <= mcnt_d;
    end

    assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized bench for branch_target_buffer against a table-level model.
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        clear;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    bit          mv   [16];
    int unsigned mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];
    logic [31:0] mcnt;

    branch_target_buffer #(.ENTRIES(16), .CTR_BITS(2)) dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .hit(hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .clear(clear), .mispredict_cnt(mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic void mreset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0;
            mctr[i] = 0;
        end
        mcnt = 0;
    endfunction

    function automatic void mlook(input logic [31:0] pc, output bit h,
                                  output bit t, output logic [31:0] tg);
        int i;
        i  = int'((pc >> 2) % 16);
        h  = mv[i] && (mtag[i] == (pc >> 6));
        t  = h && (mctr[i] >= 2);
        tg = t ? mtgt[i] : pc + 32'd4;
    endfunction

    function automatic void mupdate();
        int  i;
        bit  h;
        i = int'((upd_pc >> 2) % 16);
        h = mv[i] && (mtag[i] == (upd_pc >> 6));
        if (clear) begin
            for (int k = 0; k < 16; k++) mv[k] = 0;
        end else if (upd_valid) begin
            if (h && upd_taken) begin
                if (mctr[i] < 3) mctr[i]++;
                mtgt[i] = upd_target & 32'hFFFF_FFFC;
            end else if (h) begin
                if (mctr[i] > 0) mctr[i]--;
            end else if (upd_taken) begin
                mv[i] = 1;
                mtag[i] = upd_pc >> 6;
                mtgt[i] = upd_target & 32'hFFFF_FFFC;
                mctr[i] = 2;
            end
        end
        if (upd_valid && upd_mispredict && mcnt != 32'hFFFF_FFFF)
            mcnt = mcnt + 1;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        if (nRST) mupdate();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input bit mp, input bit cl);
        upd_valid = v;
        upd_pc = pc;
        upd_taken = tk;
        upd_target = tg;
        upd_mispredict = mp;
        clear = cl;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        mreset();
        drive(0, 0, 0, 0, 0, 0);
        fetch_pc = 32'h40;
        cyc();
        cyc();
        checks++;
        if ({hit, pred_taken} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hit got %b%b want 00", hit, pred_taken);
        end
        checks++;
        if (pred_target !== 32'h44) begin
            errors++;
            $display("FAIL reset_target got %h want 00000044", pred_target);
        end
        checks++;
        if (mispredict_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", mispredict_cnt);
        end
        #2 nRST = 1'b1;
    endtask

    task automatic test_alloc();
        drive(1, 32'h40, 1, 32'h100, 0, 0);
        fetch_pc = 32'h40;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass got hit=%b want 0", hit);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({hit, pred_taken, pred_target} !== {2'b11, 32'h100}) begin
            errors++;
            $display("FAIL alloc got %b%b %h want 11 00000100",
                     hit, pred_taken, pred_target);
        end
        checks++;
        if (dut.ctr_q[0] !== 2'd2) begin
            errors++;
            $display("FAIL alloc_ctr got %0d want 2", dut.ctr_q[0]);
        end
    endtask

    task automatic test_counter();
        logic [1:0] exp_ctr [3];
        exp_ctr[0] = 2'd1;
        exp_ctr[1] = 2'd0;
        exp_ctr[2] = 2'd0;
        for (int n = 0; n < 3; n++) begin
            drive(1, 32'h40, 0, 32'h0, 0, 0);
            cyc();
            drive(0, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (dut.ctr_q[0] !== exp_ctr[n]) begin
                errors++;
                $display("FAIL dec_ctr%0d got %0d want %0d",
                         n, dut.ctr_q[0], exp_ctr[n]);
            end
        end
        checks++;
        if ({hit, pred_taken, pred_target} !== {2'b10, 32'h44}) begin
            errors++;
            $display("FAIL dec_lookup got %b%b %h want 10 00000044",
                     hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        drive(1, 32'h40, 1, 32'h200, 0, 0);
        cyc();
        drive(1, 32'h80, 1, 32'h300, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        fetch_pc = 32'h40;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL alias_old got hit=%b want 0", hit);
        end
        fetch_pc = 32'h80;
        #1;
        checks++;
        if ({hit, pred_taken, pred_target} !== {2'b11, 32'h300}) begin
            errors++;
            $display("FAIL alias_new got %b%b %h want 11 00000300",
                     hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_clear();
        drive(1, 32'h40, 1, 32'h500, 1, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        fetch_pc = 32'h40;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL clear_upd got hit=%b want 0", hit);
        end
        fetch_pc = 32'h80;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL clear_all got hit=%b want 0", hit);
        end
        checks++;
        if (mispredict_cnt !== 32'd1) begin
            errors++;
            $display("FAIL clear_cnt got %h want 1", mispredict_cnt);
        end
    endtask

    task automatic test_random();
        bit          eh;
        bit          et;
        logic [31:0] eg;
        logic [31:0] pc;
        for (int n = 0; n < 400; n++) begin
            pc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2)
                 | $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);
            fetch_pc = ($urandom_range(0, 2) << 6)
                       | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            #1;
            mlook(fetch_pc, eh, et, eg);
            checks++;
            if ({hit, pred_taken, pred_target, mispredict_cnt}
                !== {eh, et, eg, mcnt}) begin
                errors++;
                $display("FAIL rand%0d pc=%h got %b%b %h %h want %b%b %h %h",
                         n, fetch_pc, hit, pred_taken, pred_target,
                         mispredict_cnt, eh, et, eg, mcnt);
            end
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h40, 1, 32'h600, 0, 0);
        cyc();
        drive(1, 32'h240, 1, 32'h700, 1, 0);
        fetch_pc = 32'h40;
        #2;
        nRST = 1'b0;
        mreset();
        #1;
        checks++;
        if ({hit, pred_taken, pred_target} !== {2'b00, 32'h44}) begin
            errors++;
            $display("FAIL async_rst got %b%b %h want 00 00000044",
                     hit, pred_taken, pred_target);
        end
        cyc();
        #2;
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        fetch_pc = 32'h240;
        #1;
        checks++;
        if ({hit, mispredict_cnt} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL rst_wins got hit=%b cnt=%h want 0 0",
                     hit, mispredict_cnt);
        end
    endtask

    task automatic test_saturate();
        drive(0, 0, 0, 0, 1, 0);
        force dut.mcnt_q = 32'hFFFF_FFFE;
        cyc();
        release dut.mcnt_q;
        mcnt = 32'hFFFF_FFFE;
        #1;
        checks++;
        if (mispredict_cnt !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sat_pre got %h want fffffffe", mispredict_cnt);
        end
        for (int n = 0; n < 3; n++) begin
            drive(1, $urandom, $urandom_range(0, 1) == 1, $urandom, 1, 0);
            cyc();
            checks++;
            if (mispredict_cnt !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL sat%0d got %h want ffffffff",
                         n, mispredict_cnt);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_clear();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
